// File: rtl/bram_window_sched_pkg.sv
// Shared state encoding and 3x3 tap geometry for the BRAM window scheduler.
package bram_window_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        HOLD,
        DRAIN,
        DONE
    } state_t;

    localparam int TAP_N = 9;
    localparam int TAP_W = 4;
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_N - 1);

    // Row offset of tap k inside the window (k / 3).
    function automatic logic [1:0] tap_row_off(input logic [TAP_W-1:0] k);
        logic [1:0] off;
        case (k)
            4'd0, 4'd1, 4'd2: off = 2'd0;
            4'd3, 4'd4, 4'd5: off = 2'd1;
            default:          off = 2'd2;
        endcase
        return off;
    endfunction

    // Column offset of tap k inside the window (k % 3).
    function automatic logic [1:0] tap_col_off(input logic [TAP_W-1:0] k);
        logic [1:0] off;
        case (k)
            4'd0, 4'd3, 4'd6: off = 2'd0;
            4'd1, 4'd4, 4'd7: off = 2'd1;
            default:          off = 2'd2;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/bram_window_sched_if.sv
// Pixel-source, BRAM port and tap/window signals of the window scheduler.
interface bram_window_sched_if #(
    parameter int AW = 16
);
    logic          go;
    logic          src_valid;
    logic          src_ready;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic          enb;
    logic [AW-1:0] addrb;
    logic          tap_vld;
    logic [3:0]    tap_idx;
    logic          win_valid;
    logic [AW-1:0] win_row;
    logic [AW-1:0] win_col;
    logic          dst_ready;
    logic          busy;
    logic          complete;

    // Scheduler side.
    modport master (
        input  go, src_valid, dst_ready,
        output src_ready, ena, wea, addra, enb, addrb,
               tap_vld, tap_idx, win_valid, win_row, win_col, busy, complete
    );

    // Environment side: pixel source, datapath and sequencer.
    modport slave (
        output go, src_valid, dst_ready,
        input  src_ready, ena, wea, addra, enb, addrb,
               tap_vld, tap_idx, win_valid, win_row, win_col, busy, complete
    );
endinterface

// File: rtl/bram_window_sched_addr_gen.sv
// Walks the interior window centres and produces the port-B read address of each tap.
module window_addr_gen
    import bram_window_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             step,
    output logic [AW-1:0]    addr,
    output logic [AW-1:0]    row,
    output logic [AW-1:0]    col,
    output logic [TAP_W-1:0] tap,
    output logic             first_tap,
    output logic             win_end,
    output logic             frame_end
);

    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] W_A      = AW'(IMG_W);
    localparam logic [AW-1:0] W2_A     = AW'(2 * IMG_W);
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 2);
    localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 2);

    // Address of the window's top row, (row-1)*IMG_W, kept as a running sum.
    logic [AW-1:0] top_base;
    logic [AW-1:0] row_off;

    always_comb begin
        // NOTE: default first so every path assigns row_off and no latch is inferred.
        row_off = '0;
        case (tap_row_off(tap))
            2'd1:    row_off = W_A;
            2'd2:    row_off = W2_A;
            default: row_off = '0;
        endcase
        addr = top_base + row_off + col - ONE + AW'(tap_col_off(tap));
    end

    assign first_tap = (tap == '0);
    assign win_end   = (tap == TAP_LAST);
    assign frame_end = win_end && (row == ROW_LAST) && (col == COL_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!RESET) begin
            tap      <= '0;
            row      <= ONE;
            col      <= ONE;
            top_base <= '0;
        end else if (step) begin
            if (win_end) begin
                tap <= '0;
                if (frame_end) begin
                    row      <= ONE;
                    col      <= ONE;
                    top_base <= '0;
                end else if (col == COL_LAST) begin
                    col      <= ONE;
                    row      <= row + ONE;
                    top_base <= top_base + W_A;
                end else begin
                    col <= col + ONE;
                end
            end else begin
                tap <= tap + TAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/bram_window_sched.sv
// Frame-buffer BRAM sequencer: loads one frame on port A, then reads every 3x3 interior window on port B.
module bram_window_sched
    import bram_window_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    bram_window_sched_if.master    bus
);

    localparam logic [AW-1:0] LAST_PIX = AW'(IMG_W * IMG_H - 1);

    state_t           state, state_nxt;
    logic [AW-1:0]    addra_q;
    logic [AW-1:0]    gen_addr, gen_row, gen_col;
    logic [TAP_W-1:0] gen_tap;
    logic             first_tap, win_end, frame_end;
    logic             wr_en, rd_en, src_ready_c, busy_c, complete_c;

    logic             tap_vld_q;
    logic [TAP_W-1:0] tap_idx_q;
    logic [AW-1:0]    win_row_q, win_col_q;

    window_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW)
    ) u_addr_gen (
        .CLK       (CLK),
        .RESET     (RESET),
        .step      (rd_en),
        .addr      (gen_addr),
        .row       (gen_row),
        .col       (gen_col),
        .tap       (gen_tap),
        .first_tap (first_tap),
        .win_end   (win_end),
        .frame_end (frame_end)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // dst_ready is only consulted while the next read would be tap 0.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (bus.go) state_nxt = LOAD;
            LOAD:      if (wr_en && addra_q == LAST_PIX) state_nxt = RUN;
            RUN, HOLD: begin
                if (first_tap && !bus.dst_ready) state_nxt = HOLD;
                else if (frame_end)              state_nxt = DRAIN;
                else                             state_nxt = RUN;
            end
            DRAIN:     state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_ready_c = (state == LOAD);
        wr_en       = src_ready_c && bus.src_valid;
        rd_en       = (state == RUN || state == HOLD) && (!first_tap || bus.dst_ready);
        busy_c      = (state != IDLE);
        complete_c  = (state == DONE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)      addra_q <= '0;
        else if (wr_en)  addra_q <= (addra_q == LAST_PIX) ? '0 : addra_q + AW'(1);
    end

    // Tap tag and window centre travel one cycle behind the read to meet doutb.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tap_vld_q <= 1'b0;
            tap_idx_q <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            tap_vld_q <= rd_en;
            tap_idx_q <= rd_en ? gen_tap : '0;
            if (rd_en) begin
                win_row_q <= gen_row;
                win_col_q <= gen_col;
            end
        end
    end

    assign bus.src_ready = src_ready_c;
    assign bus.ena       = wr_en;
    assign bus.wea       = wr_en;
    assign bus.addra     = addra_q;
    assign bus.enb       = rd_en;
    assign bus.addrb     = gen_addr;
    assign bus.tap_vld   = tap_vld_q;
    assign bus.tap_idx   = tap_idx_q;
    assign bus.win_valid = tap_vld_q && (tap_idx_q == TAP_LAST);
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.busy      = busy_c;
    assign bus.complete  = complete_c;

endmodule

// File: tb/tb_bram_window_sched.sv
// Randomized bench for bram_window_sched on a 4x4 frame against an arithmetic window-walk model.
module tb_bram_window_sched;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int AW   = 4;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);
    localparam int NRD  = NWIN * 9;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    bram_window_sched_if #(.AW(AW)) bus ();

    bram_window_sched #(
        .IMG_W (W),
        .IMG_H (H),
        .AW    (AW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference walk: read i belongs to window i/9, tap i%9; windows row-major over the interior.
    function automatic int win_r(input int i);
        return 1 + (i / 9) / (W - 2);
    endfunction

    function automatic int win_c(input int i);
        return 1 + (i / 9) % (W - 2);
    endfunction

    function automatic int exp_addr(input int i);
        int k;
        k = i % 9;
        return (win_r(i) - 1 + k / 3) * W + (win_c(i) - 1 + k % 3);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {bus.src_ready, bus.ena, bus.wea, bus.addra, bus.enb, bus.addrb,
                               bus.tap_vld, bus.tap_idx, bus.win_valid, bus.win_row, bus.win_col,
                               bus.complete}, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    // gap_mode: 0 = gaps after pixels 3 and 10, 1 = random gaps.
    // stall_mode: 0 = always ready, 1 = 5-cycle stall before window 2, 2 = random dst_ready.
    // abort_at: read index at which reset is asserted, -1 for none.
    task automatic run_frame(input int gap_mode, input int stall_mode, input int abort_at,
                             input bit go_noise);
        int  wr        = 0;
        int  rd        = 0;
        int  cyc       = 0;
        int  stall_cnt = 0;
        int  pend_i    = 0;
        bit  pend      = 0;
        bit  gap_next  = 0;
        bit  exp_en;
        logic dst;
        int  k;

        @(posedge CLK); #1;
        bus.go        = 1'b1;
        bus.src_valid = 1'b1;
        bus.dst_ready = 1'b1;
        @(negedge CLK);
        check("idle_busy", bus.busy, 0);
        check("idle_ena", bus.ena, 0);
        @(posedge CLK); #1;
        bus.go = 1'b0;

        while (wr < NPIX && cyc < 300) begin
            if (gap_mode == 0) bus.src_valid = !gap_next;
            else               bus.src_valid = ($urandom_range(0, 3) != 0);
            bus.go        = go_noise && ($urandom_range(0, 3) == 0);
            bus.dst_ready = $urandom_range(0, 1);
            @(negedge CLK);
            check("load_src_ready", bus.src_ready, 1);
            check("load_ena", bus.ena, bus.src_valid);
            check("load_wea", bus.wea, bus.src_valid);
            check("load_enb", bus.enb, 0);
            if (bus.src_valid) check("load_addra", bus.addra, wr);
            @(posedge CLK); #1;
            if (bus.src_valid) begin
                gap_next = (wr == 3 || wr == 10);
                wr++;
            end else begin
                gap_next = 1'b0;
            end
            cyc++;
        end
        if (wr < NPIX) begin
            check("load_timeout", wr, NPIX);
            return;
        end

        cyc = 0;
        while ((rd < NRD || pend) && cyc < 2000) begin
            case (stall_mode)
                1: begin
                    dst = 1'b1;
                    if (rd == 9 && stall_cnt < 5) begin
                        dst = 1'b0;
                        stall_cnt++;
                    end
                end
                2:       dst = ($urandom_range(0, 2) != 0);
                default: dst = 1'b1;
            endcase
            bus.dst_ready = dst;
            bus.go        = go_noise && ($urandom_range(0, 3) == 0);
            bus.src_valid = $urandom_range(0, 1);

            if (rd == abort_at) begin
                #1 RESET = 1'b0;
                bus.go = 1'b1;
                #1;
                check_all_zero("abort");
                @(posedge CLK); #1;
                @(negedge CLK);
                check_all_zero("abort_hold");
                RESET  = 1'b1;
                bus.go = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge CLK);
                    check("abort_no_complete", bus.complete, 0);
                    check("abort_idle_busy", bus.busy, 0);
                end
                return;
            end

            @(negedge CLK);
            check("run_src_ready", bus.src_ready, 0);
            check("run_ena", bus.ena, 0);
            check("run_complete", bus.complete, 0);
            check("run_busy", bus.busy, 1);
            if (pend) begin
                k = pend_i % 9;
                check("tap_vld", bus.tap_vld, 1);
                check("tap_idx", bus.tap_idx, k);
                check("win_valid", bus.win_valid, (k == 8));
                if (k == 8) begin
                    check("win_row", bus.win_row, win_r(pend_i));
                    check("win_col", bus.win_col, win_c(pend_i));
                end
            end else begin
                check("tap_vld_idle", bus.tap_vld, 0);
                check("win_valid_idle", bus.win_valid, 0);
            end
            if (rd < NRD) begin
                exp_en = (rd % 9 != 0) || dst;
                check("run_enb", bus.enb, exp_en);
                check("run_addrb", bus.addrb, exp_addr(rd));
                pend   = exp_en;
                pend_i = rd;
                if (exp_en) rd++;
            end else begin
                check("drain_enb", bus.enb, 0);
                pend = 1'b0;
            end
            @(posedge CLK); #1;
            cyc++;
        end
        if (rd < NRD || pend) begin
            check("run_timeout", rd, NRD);
            return;
        end

        bus.go = 1'b0;
        @(negedge CLK);
        check("done_complete", bus.complete, 1);
        check("done_busy", bus.busy, 1);
        check("done_enb", bus.enb, 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("end_complete", bus.complete, 0);
        check("end_busy", bus.busy, 0);
        check("end_addra", bus.addra, 0);
        check("end_addrb", bus.addrb, 0);
    endtask

    initial begin
        bus.go        = 1'b0;
        bus.src_valid = 1'b0;
        bus.dst_ready = 1'b0;
        RESET         = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_all_zero("post_reset");

        run_frame(0, 0, -1, 1'b0);
        run_frame(1, 1, -1, 1'b1);
        run_frame(1, 2, 22, 1'b1);
        run_frame(0, 0, -1, 1'b0);
        for (int f = 0; f < 3; f++) run_frame(1, 2, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
